div_req_ctrl: RTL and testbench

- Upstream command stage for `div_4bit_restoring`.
- Accepts operand pairs over a valid/ready handshake and drives the divider's `start`/operand inputs for a fixed latency.
- Captures quotient and remainder into a held response with its own valid/ready handshake.
- Handles divide-by-zero locally without running the divider. Sits between the board-level operand source and the divider.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_req_ctrl.sv | 115 +++++++++++
 tb/tb_div_req_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Types and constants shared between the divider command stage and its neighbours.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESP
  } div_ctrl_state_t;

  localparam int unsigned DIV_W = 4;
  localparam logic [DIV_W-1:0] DIV_DBZ_QUOT = '1;

endpackage : div_pkg

// File: rtl/div_req_ctrl.sv
// Command stage for div_4bit_restoring: request handshake, fixed-latency start,
// held response with local divide-by-zero handling.
module div_req_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH       = DIV_W,
  parameter int unsigned DIV_LATENCY = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             req_ready,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_dbz,
  input  logic             rsp_ready
);

  localparam int unsigned CW = $clog2(DIV_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_LATENCY - 1);

  div_ctrl_state_t  state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_b != '0) begin
            a_d     = req_a;
            b_d     = req_b;
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            // Zero divisor is answered locally; the divider never sees it.
            quot_d  = '1;
            rem_d   = req_a;
            dbz_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          dbz_d   = 1'b0;
          start_d = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready     = (state_q == ST_IDLE) && !rst;
  assign rsp_valid     = (state_q == ST_RESP);
  assign div_start     = start_q;
  assign div_a         = a_q;
  assign div_b         = b_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_dbz       = dbz_q;

endmodule : div_req_ctrl

// File: tb/tb_div_req_ctrl.sv
// Self-checking bench for div_req_ctrl with a behavioural divider stand-in.
module tb_div_req_ctrl;

  localparam int L = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;
  logic       req_ready;
  logic       div_start;
  logic [3:0] div_a, div_b;
  logic [3:0] div_quotient, div_remainder;
  logic       rsp_valid;
  logic [3:0] rsp_quotient, rsp_remainder;
  logic       rsp_dbz;
  logic       rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  div_req_ctrl #(.WIDTH(4), .DIV_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // Divider stand-in: result valid from the L-th consecutive cycle of start, inverted junk before.
  int unsigned dv_cnt = 0;
  always @(posedge clk) dv_cnt <= div_start ? dv_cnt + 1 : 0;

  logic [3:0] tq, tr;
  always @* begin
    if (div_b != 0) begin
      tq = div_a / div_b;
      tr = div_a % div_b;
    end else begin
      tq = '0;
      tr = '0;
    end
    if (div_start && dv_cnt >= L - 1) begin
      div_quotient  = tq;
      div_remainder = tr;
    end else begin
      div_quotient  = ~tq;
      div_remainder = ~tr;
    end
  end

  // Protocol observers, judged later by test_invariants.
  int   overlap = 0, operand_chg = 0, min_gap = 999, low_run = 0;
  bit   seen_run = 0, prev_start = 0;
  logic [3:0] prev_a = '0, prev_b = '0;
  always @(posedge clk) begin
    #1;
    if (rsp_valid && req_ready) overlap++;
    if (prev_start && div_start && (div_a != prev_a || div_b != prev_b)) operand_chg++;
    if (rst) begin
      seen_run = 0;
      low_run  = 0;
    end else if (div_start) begin
      if (!prev_start && seen_run && low_run < min_gap) min_gap = low_run;
      seen_run = 1;
      low_run  = 0;
    end else begin
      low_run++;
    end
    prev_start = div_start;
    prev_a = div_a;
    prev_b = div_b;
  end

  bit         pend = 0;
  logic [3:0] pend_a, pend_b;

  // Drives one transaction and reports what was observed; callers do the judging.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold,
                        output int cyc, output int starts,
                        output logic [3:0] q, output logic [3:0] r, output logic dbz,
                        output bit hold_ok, output bit back_idle, output bit to);
    int n;
    cyc = 0; starts = 0; q = '0; r = '0; dbz = 0; hold_ok = 1; back_idle = 0; to = 0;
    @(negedge clk);
    req_valid = 1; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      to = 1;
      req_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 0; req_a = 4'($urandom); req_b = 4'($urandom);
    cyc = 1;
    while (!rsp_valid && cyc < 60) begin
      if (div_start) starts++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!rsp_valid) begin
      to = 1;
      return;
    end
    q = rsp_quotient; r = rsp_remainder; dbz = rsp_dbz;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || req_ready || rsp_quotient !== q || rsp_remainder !== r || rsp_dbz !== dbz)
        hold_ok = 0;
    end
    @(negedge clk);
    rsp_ready = 1;
    if (pend) begin
      req_valid = 1; req_a = pend_a; req_b = pend_b;
      pend = 0;
    end
    @(posedge clk);
    #1;
    rsp_ready = 0;
    back_idle = !rsp_valid && req_ready && rsp_quotient === q && rsp_remainder === r && rsp_dbz === dbz;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, div_start, div_a, div_b, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {req_ready, div_start, div_a, div_b, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz});
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || div_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ready=%b valid=%b start=%b want 1 0 0", req_ready, rsp_valid, div_start);
    end
  endtask

  // Reference: plain arithmetic, zero divisor answered with all-ones/dividend after one cycle.
  task automatic check_op(input string name, input logic [3:0] a, input logic [3:0] b, input int hold);
    int cyc, starts;
    logic [3:0] q, r, eq, er;
    logic dbz, edbz;
    bit hold_ok, back_idle, to;
    int ecyc, estarts;
    run_op(a, b, hold, cyc, starts, q, r, dbz, hold_ok, back_idle, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s timeout a=%0d b=%0d", name, a, b);
      return;
    end
    eq = (b == 0) ? 4'hF : a / b;
    er = (b == 0) ? a : a % b;
    edbz = (b == 0);
    ecyc = (b == 0) ? 1 : L + 1;
    estarts = (b == 0) ? 0 : L;
    checks++;
    if (q !== eq || r !== er || dbz !== edbz) begin
      errors++;
      $display("FAIL %s_data a=%0d b=%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
               name, a, b, q, r, dbz, eq, er, edbz);
    end
    checks++;
    if (cyc !== ecyc) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, cyc, ecyc);
    end
    checks++;
    if (starts !== estarts) begin
      errors++;
      $display("FAIL %s_start_cycles got %0d want %0d", name, starts, estarts);
    end
    checks++;
    if (!hold_ok || !back_idle) begin
      errors++;
      $display("FAIL %s_release got hold=%b idle=%b want 1 1", name, hold_ok, back_idle);
    end
  endtask

  task automatic test_basic();
    check_op("a4_b2", 4'd4, 4'd2, 0);
    check_op("a3_b5", 4'd3, 4'd5, 1);
  endtask

  task automatic test_back_to_back();
    min_gap = 999;
    pend = 1; pend_a = 4'd9; pend_b = 4'd4;
    check_op("b2b_first", 4'd4, 4'd2, 0);
    check_op("b2b_9_4", 4'd9, 4'd4, 0);
    checks++;
    if (min_gap < 2 || min_gap == 999) begin
      errors++;
      $display("FAIL b2b_start_gap got %0d want >=2", min_gap);
    end
  endtask

  task automatic test_dbz();
    check_op("dbz_9_0", 4'd9, 4'd0, 0);
  endtask

  task automatic test_hold();
    check_op("hold5", 4'd13, 4'd3, 5);
    check_op("hold5_dbz", 4'd6, 4'd0, 5);
  endtask

  task automatic test_reset_mid_run();
    bit bad;
    int n;
    @(negedge clk);
    req_valid = 1; req_a = 4'd7; req_b = 4'd3;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (div_start !== 1'b1) begin
      errors++;
      $display("FAIL midrun_running got %b want 1", div_start);
    end
    rst = 1;
    @(posedge clk);
    #1;
    checks++;
    if (div_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_quotient !== 4'd0) begin
      errors++;
      $display("FAIL midrun_abort got start=%b valid=%b ready=%b q=%0d want 0 0 0 0",
               div_start, rsp_valid, req_ready, rsp_quotient);
    end
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid || div_start || !req_ready) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrun_no_response got activity=1 want 0");
    end
    check_op("after_reset_7_3", 4'd7, 4'd3, 0);
  endtask

  task automatic test_random();
    logic [3:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      check_op("rand", a, b, $urandom_range(0, 3));
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL ready_valid_overlap got %0d want 0", overlap);
    end
    checks++;
    if (operand_chg != 0) begin
      errors++;
      $display("FAIL operand_change_during_start got %0d want 0", operand_chg);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_dbz();
    test_hold();
    test_reset_mid_run();
    test_random();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_req_ctrl
